intc_ctrl: RTL and testbench

Memory-mapped interrupt controller sitting between the I/O devices (KEY, SW, timer) and the CPU. It collects per-device level `intr` lines, masks and prioritizes them, drives a single `intr` to the CPU, and sequences each interrupt through an acknowledge (IID read) and end-of-interrupt (IEOI write) handshake. It shares the CPU's single interrupt input among NSRC requesters, with no nesting.

---
 rtl/intc_ctrl_if.sv | 24 ++
 rtl/intc_ctrl.sv | 168 ++++++++++++++++
 tb/tb_intc_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/intc_ctrl_if.sv
// Bus-side signal bundle for intc_ctrl: address, write strobe, device requests and CPU interrupt.
// The data bus is bidirectional and stays a plain inout port on the controller.
interface intc_ctrl_if #(
    parameter int NSRC = 4
);
    logic [31:0]     abus;
    logic            we;
    logic [NSRC-1:0] irq;
    logic            intr;

    modport master (
        output abus,
        output we,
        output irq,
        input  intr
    );

    modport slave (
        input  abus,
        input  we,
        input  irq,
        output intr
    );
endinterface

// File: rtl/intc_ctrl.sv
// Memory-mapped interrupt controller: masks and prioritises NSRC level requests, then sequences IID ack / IEOI.
// Optional feature macro INTC_ROTATE_EN selects round-robin priority instead of fixed lowest-index.
module intc_ctrl #(
    parameter int          NSRC = 4,
    parameter logic [31:0] BASE = 32'hF000_0200
) (
    input  logic         clk,
    input  logic         rst,
    intc_ctrl_if.slave   bus,
    inout  wire  [31:0]  dbus
);
    localparam logic [31:0] A_MASK = BASE;
    localparam logic [31:0] A_PEND = BASE + 32'd4;
    localparam logic [31:0] A_IID  = BASE + 32'd8;
    localparam logic [31:0] A_STAT = BASE + 32'd12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        SVC  = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [NSRC-1:0] ipend;
    logic [NSRC-1:0] imask;
    logic [NSRC-1:0] masked;
    logic [2:0]      cur_id;
    logic [2:0]      winner;
    logic            intr_q;
    logic            intr_nxt;
    logic            rd_iid;
    logic            wr_mask;
    logic            wr_eoi;
    logic            eoi_ok;
    logic            ack;
    logic            oe;
    logic [31:0]     rdata;

    wire unused_dbus = &{1'b0, dbus};

    // Lowest set index wins; shifting avoids variable-width bit selects.
    function automatic logic [2:0] pick_fixed(input logic [NSRC-1:0] m);
        logic [2:0]      w;
        logic [NSRC-1:0] sh;
        w = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            sh = m >> i;
            if (sh[0]) w = 3'(i);
        end
        return w;
    endfunction

`ifdef INTC_ROTATE_EN
    logic [2:0] rp;

    // First set bit searching upward from the rotate pointer, wrapping at NSRC.
    function automatic logic [2:0] pick_rot(input logic [NSRC-1:0] m, input logic [2:0] p);
        logic [2:0]      w;
        logic [NSRC-1:0] sh;
        logic            found;
        int              j;
        w     = '0;
        found = 1'b0;
        for (int k = 0; k < NSRC; k++) begin
            j = int'(p) + k;
            if (j >= NSRC) j = j - NSRC;
            sh = m >> j;
            if (!found && sh[0]) begin
                w     = 3'(j);
                found = 1'b1;
            end
        end
        return w;
    endfunction

    assign winner = pick_rot(masked, rp);
`else
    assign winner = pick_fixed(masked);
`endif

    assign masked  = ipend & imask;
    assign rd_iid  = !bus.we && (bus.abus == A_IID);
    assign wr_mask = bus.we && (bus.abus == A_MASK);
    assign wr_eoi  = bus.we && (bus.abus == A_STAT);
    assign eoi_ok  = (state == SVC) && wr_eoi && (dbus[2:0] == cur_id);
    assign ack     = (state == PEND) && (state_nxt == SVC);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (masked != '0) state_nxt = PEND;
            PEND: begin
                if (masked == '0)  state_nxt = IDLE;
                else if (rd_iid)   state_nxt = SVC;
            end
            SVC:  if (eoi_ok) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // intr falls on the acknowledging edge, not one cycle later.
        intr_nxt = (state == PEND) && (state_nxt == PEND);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            ipend  <= '0;
            imask  <= '0;
            cur_id <= '0;
            intr_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            ipend  <= bus.irq;
            intr_q <= intr_nxt;
            if (wr_mask) imask <= dbus[NSRC-1:0];
            if (ack)     cur_id <= winner;
            else if (eoi_ok) cur_id <= '0;
        end
    end

`ifdef INTC_ROTATE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rp <= '0;
        end else if (eoi_ok) begin
            if (cur_id == 3'(NSRC - 1)) rp <= '0;
            else                        rp <= cur_id + 3'd1;
        end
    end
`endif

    assign bus.intr = intr_q;

    // Read path is purely combinational from current state; IID read has no side effect here.
    always_comb begin
        oe    = 1'b0;
        rdata = '0;
        if (!bus.we) begin
            case (bus.abus)
                A_MASK: begin
                    oe    = 1'b1;
                    rdata = 32'(imask);
                end
                A_PEND: begin
                    oe    = 1'b1;
                    rdata = 32'(ipend);
                end
                A_IID: begin
                    oe = 1'b1;
                    case (state)
                        PEND:    rdata = {29'b0, winner};
                        SVC:     rdata = {29'b0, cur_id};
                        default: rdata = 32'hFFFF_FFFF;
                    endcase
                end
                A_STAT: begin
                    oe    = 1'b1;
                    rdata = {23'b0, (state == SVC), 5'b0, cur_id};
                end
                default: begin
                    oe    = 1'b0;
                    rdata = '0;
                end
            endcase
        end
    end

    assign dbus = oe ? rdata : 32'bz;
endmodule

// File: tb/tb_intc_ctrl.sv
// Directed self-checking bench for intc_ctrl: register access, ack/EOI sequencing, masking, async reset.
module tb_intc_ctrl;
    localparam logic [31:0] BASE   = 32'hF000_0200;
    localparam logic [31:0] A_MASK = BASE;
    localparam logic [31:0] A_PEND = BASE + 32'd4;
    localparam logic [31:0] A_IID  = BASE + 32'd8;
    localparam logic [31:0] A_STAT = BASE + 32'd12;
    localparam logic [31:0] A_NONE = 32'hF000_0210;

    logic        clk;
    logic        rst;
    logic        tb_oe;
    logic [31:0] tb_dout;
    wire  [31:0] dbus;
    int          n_cmp;
    int          n_err;
    logic [31:0] rv;
    logic [31:0] exp_id;

    intc_ctrl_if #(.NSRC(4)) bus ();

    assign dbus = tb_oe ? tb_dout : 32'bz;

    intc_ctrl #(.NSRC(4), .BASE(BASE)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus.slave),
        .dbus (dbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus.abus = addr;
        bus.we   = 1'b1;
        tb_oe    = 1'b1;
        tb_dout  = data;
        @(negedge clk);
        bus.we   = 1'b0;
        tb_oe    = 1'b0;
        bus.abus = 32'h0;
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data);
        @(negedge clk);
        bus.abus = addr;
        bus.we   = 1'b0;
        #1 data = dbus;
        @(negedge clk);
        bus.abus = 32'h0;
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst      = 1'b1;
        tb_oe    = 1'b0;
        tb_dout  = '0;
        bus.abus = 32'h0;
        bus.we   = 1'b0;
        bus.irq  = 4'b0000;
        #12;
        chk("rst_intr", {31'b0, bus.intr}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        rd(A_MASK, rv); chk("rst_imask", rv, 32'h0);
        rd(A_STAT, rv); chk("rst_istat", rv, 32'h0);
        rd(A_IID,  rv); chk("rst_iid_spur", rv, 32'hFFFF_FFFF);

        // Single source, three-edge latency.
        wr(A_MASK, 32'h5);
        rd(A_MASK, rv); chk("imask_rd", rv, 32'h5);
        @(negedge clk);
        bus.irq = 4'b0100;
        edges(1); chk("lat_e1", {31'b0, bus.intr}, 32'h0);
        edges(1); chk("lat_e2", {31'b0, bus.intr}, 32'h0);
        edges(1); chk("lat_e3", {31'b0, bus.intr}, 32'h1);
        rd(A_PEND, rv); chk("ipend", rv, 32'h4);
        rd(A_STAT, rv); chk("istat_pend", rv, 32'h0);
        rd(A_IID,  rv); chk("iid_src2", rv, 32'h2);
        chk("intr_after_ack", {31'b0, bus.intr}, 32'h0);
        rd(A_STAT, rv); chk("istat_svc2", rv, 32'h102);

        // Unmapped read: the block must not drive, so the bench's zero stays visible.
        @(negedge clk);
        bus.abus = A_NONE;
        tb_oe    = 1'b1;
        tb_dout  = 32'h0;
        #1 chk("unmapped_hiz", dbus, 32'h0);
        @(negedge clk);
        tb_oe    = 1'b0;
        bus.abus = 32'h0;

        wr(A_PEND, 32'hF);
        rd(A_PEND, rv); chk("ipend_ro", rv, 32'h4);
        wr(A_STAT, 32'h3);
        rd(A_STAT, rv); chk("eoi_wrong_id", rv, 32'h102);
        bus.irq = 4'b0000;
        wr(A_STAT, 32'h2);
        rd(A_STAT, rv); chk("istat_after_eoi", rv, 32'h0);
        edges(2); chk("idle_intr", {31'b0, bus.intr}, 32'h0);

        // Two sources: priority and re-assertion after EOI.
        wr(A_MASK, 32'hF);
        @(negedge clk);
        bus.irq = 4'b0110;
        edges(3); chk("two_intr", {31'b0, bus.intr}, 32'h1);
        rd(A_IID,  rv); chk("iid_first", rv, 32'h1);
        rd(A_STAT, rv); chk("istat_svc1", rv, 32'h101);
        wr(A_STAT, 32'h3);
        rd(A_STAT, rv); chk("eoi3_ignored", rv, 32'h101);
        rd(A_IID,  rv); chk("iid_in_svc", rv, 32'h1);
        rd(A_STAT, rv); chk("svc_no_change", rv, 32'h101);
        wr(A_STAT, 32'h1);
        edges(1); chk("eoi1_e1", {31'b0, bus.intr}, 32'h0);
        edges(1); chk("eoi1_reassert", {31'b0, bus.intr}, 32'h1);
`ifdef INTC_ROTATE_EN
        exp_id = 32'h2;
`else
        exp_id = 32'h1;
`endif
        rd(A_IID, rv); chk("iid_second", rv, exp_id);
        wr(A_STAT, exp_id);
        edges(2); chk("eoi2_reassert", {31'b0, bus.intr}, 32'h1);
        rd(A_IID, rv); chk("iid_third", rv, 32'h1);
        bus.irq = 4'b0000;
        wr(A_STAT, 32'h1);
        rd(A_STAT, rv); chk("istat_clear", rv, 32'h0);

        // Masking off a pending request returns to IDLE.
        @(negedge clk);
        bus.irq = 4'b0001;
        edges(3); chk("mask_pre_intr", {31'b0, bus.intr}, 32'h1);
        wr(A_MASK, 32'h0);
        edges(1); chk("mask_off_intr", {31'b0, bus.intr}, 32'h0);
        rd(A_STAT, rv); chk("mask_off_istat", rv, 32'h0);
        rd(A_IID,  rv); chk("mask_off_spur", rv, 32'hFFFF_FFFF);

        // Asynchronous reset in the middle of service.
        wr(A_MASK, 32'hF);
        @(negedge clk);
        bus.irq = 4'b1000;
        edges(3);
        rd(A_IID,  rv); chk("iid_src3", rv, 32'h3);
        rd(A_STAT, rv); chk("istat_svc3", rv, 32'h103);
        @(negedge clk);
        bus.abus = A_MASK;
        #2 rst = 1'b1;
        #1 chk("arst_imask", dbus, 32'h0);
        bus.abus = A_STAT;
        #1 chk("arst_istat", dbus, 32'h0);
        chk("arst_intr", {31'b0, bus.intr}, 32'h0);
        @(negedge clk);
        bus.abus = 32'h0;
        rst = 1'b0;

        // Asynchronous reset drops a raised intr without a clock edge.
        wr(A_MASK, 32'hF);
        edges(3); chk("pre_arst_intr", {31'b0, bus.intr}, 32'h1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("arst_intr_pend", {31'b0, bus.intr}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
